// File: rtl/fifo_bank4_pkg.sv
// Shared constants and helpers for the four-FIFO bank and the arbiter that feeds it.
package fifo_bank4_pkg;

  localparam int DATA_W    = 12;
  localparam int N_FIFO    = 4;
  localparam int DEPTH     = 8;
  localparam int AF_THRESH = 6;

  // Isolates the lowest set bit; zero input gives zero.
  function automatic logic [N_FIFO-1:0] lowest_bit(input logic [N_FIFO-1:0] v);
    return v & (~v + N_FIFO'(1));
  endfunction

endpackage

// File: rtl/fifo_bank4_if.sv
// Bus between the arbiter (master) and the FIFO bank (slave).
// Handshake: push[i]/pop[i] are single-cycle strobes sampled at the rising edge; the bank never
// stalls, it reports back-pressure through almost_full/full and rejected strobes through error.
interface fifo_bank4_if #(
  parameter int DATA_W = fifo_bank4_pkg::DATA_W
);
  import fifo_bank4_pkg::*;

  logic [DATA_W-1:0]        data_in;
  logic [N_FIFO-1:0]        push;
  logic [N_FIFO-1:0]        pop;
  logic [N_FIFO*DATA_W-1:0] data_out;
  logic [N_FIFO-1:0]        empty;
  logic [N_FIFO-1:0]        almost_full;
  logic [N_FIFO-1:0]        full;
  logic [N_FIFO-1:0]        error;

  modport master (
    output data_in, push, pop,
    input  data_out, empty, almost_full, full, error
  );

  modport slave (
    input  data_in, push, pop,
    output data_out, empty, almost_full, full, error
  );

endinterface

// File: rtl/fifo_bank4_single.sv
// One circular-buffer FIFO with registered read word, occupancy flags and an error pulse.
module fifo_single
  import fifo_bank4_pkg::*;
#(
  parameter int DATA_W    = fifo_bank4_pkg::DATA_W,
  parameter int DEPTH     = fifo_bank4_pkg::DEPTH,
  parameter int AF_THRESH = fifo_bank4_pkg::AF_THRESH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              push,
  input  logic              pop,
  input  logic              push_drop,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              almost_full,
  output logic              full,
  output logic              error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              error_q, error_d;
  logic              push_ok, pop_ok;

  always_comb begin
    empty       = (cnt_q == '0);
    full        = (cnt_q == DEPTH_C);
    almost_full = (cnt_q >= AF_C);

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    error_d = push_drop | (push & ~push_ok) | (pop & empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      error_q    <= error_d;
    end
  end

  // Storage is left unreset; occupancy alone decides which words are valid.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out = data_out_q;
  assign error    = error_q;

endmodule

// File: rtl/fifo_bank4.sv
// Four independent FIFOs sharing one write bus; a multi-bit push writes only the lowest index.
module fifo_bank4
  import fifo_bank4_pkg::*;
#(
  parameter int DATA_W    = fifo_bank4_pkg::DATA_W,
  parameter int DEPTH     = fifo_bank4_pkg::DEPTH,
  parameter int AF_THRESH = fifo_bank4_pkg::AF_THRESH
) (
  input  logic         clk,
  input  logic         reset,
  fifo_bank4_if.slave  bus
);

  logic [N_FIFO-1:0] push_sel;
  logic [N_FIFO-1:0] push_drop;

  always_comb begin
    push_sel  = lowest_bit(bus.push);
    push_drop = bus.push & ~push_sel;
  end

  for (genvar i = 0; i < N_FIFO; i++) begin : g_fifo
    fifo_single #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .data_in     (bus.data_in),
      .push        (push_sel[i]),
      .pop         (bus.pop[i]),
      .push_drop   (push_drop[i]),
      .data_out    (bus.data_out[i*DATA_W +: DATA_W]),
      .empty       (bus.empty[i]),
      .almost_full (bus.almost_full[i]),
      .full        (bus.full[i]),
      .error       (bus.error[i])
    );
  end

endmodule

// File: tb/tb_fifo_bank4.sv
// Bench for fifo_bank4: directed scenarios then random traffic, checked against queue models.
module tb_fifo_bank4;
  import fifo_bank4_pkg::*;

  localparam int W = DATA_W;

  logic clk;
  logic reset;

  fifo_bank4_if #(.DATA_W(W)) bus ();

  fifo_bank4 #(.DATA_W(W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: one expected queue per FIFO plus expected registered outputs
  typedef logic [W-1:0] word_q_t[$];
  word_q_t        exp_q [N_FIFO];
  logic [W-1:0]   exp_dout [N_FIFO];
  logic [N_FIFO-1:0] exp_err;

  int n_checks;
  int n_fail;

  task automatic model_edge(input logic [3:0] p, input logic [3:0] o, input logic [W-1:0] d,
                            input logic r);
    int first;
    first = -1;
    for (int i = 0; i < N_FIFO; i++)
      if (p[i] && first < 0) first = i;
    for (int i = 0; i < N_FIFO; i++) begin
      bit do_pop, do_push, want_push;
      if (r) begin
        exp_q[i].delete();
        exp_dout[i] = '0;
        exp_err[i]  = 1'b0;
      end else begin
        want_push  = p[i] && (i == first);
        do_pop     = o[i] && (exp_q[i].size() > 0);
        do_push    = want_push && ((exp_q[i].size() < DEPTH) || do_pop);
        exp_err[i] = (p[i] && !want_push) || (want_push && !do_push) ||
                     (o[i] && exp_q[i].size() == 0);
        if (do_pop) exp_dout[i] = exp_q[i].pop_front();
        if (do_push) exp_q[i].push_back(d);
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [N_FIFO*W-1:0] e_do;
    logic [3:0] e_em, e_af, e_fu;
    for (int i = 0; i < N_FIFO; i++) begin
      e_do[i*W +: W] = exp_dout[i];
      e_em[i] = (exp_q[i].size() == 0);
      e_af[i] = (exp_q[i].size() >= AF_THRESH);
      e_fu[i] = (exp_q[i].size() == DEPTH);
    end
    n_checks++;
    assert (bus.data_out === e_do) else begin
      n_fail++; $error("FAIL %s data_out got %h want %h", tag, bus.data_out, e_do);
    end
    n_checks++;
    assert (bus.empty === e_em) else begin
      n_fail++; $error("FAIL %s empty got %b want %b", tag, bus.empty, e_em);
    end
    n_checks++;
    assert (bus.almost_full === e_af) else begin
      n_fail++; $error("FAIL %s almost_full got %b want %b", tag, bus.almost_full, e_af);
    end
    n_checks++;
    assert (bus.full === e_fu) else begin
      n_fail++; $error("FAIL %s full got %b want %b", tag, bus.full, e_fu);
    end
    n_checks++;
    assert (bus.error === exp_err) else begin
      n_fail++; $error("FAIL %s error got %b want %b", tag, bus.error, exp_err);
    end
  endtask

  // driver: apply one cycle of inputs, advance the model at the edge, check 1 time unit later
  task automatic step(input logic [3:0] p, input logic [3:0] o, input logic [W-1:0] d,
                      input logic r, input string tag);
    bus.push    = p;
    bus.pop     = o;
    bus.data_in = d;
    reset       = r;
    @(posedge clk);
    model_edge(p, o, d, r);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0]   p, o;
    logic [W-1:0] d;
    n_checks = 0;
    n_fail   = 0;
    bus.push = '0; bus.pop = '0; bus.data_in = '0; reset = 1'b1;
    for (int i = 0; i < N_FIFO; i++) begin
      exp_dout[i] = '0;
      exp_err[i]  = 1'b0;
    end

    // reset for two cycles, then idle
    step(4'b0000, 4'b0000, '0, 1'b1, "reset0");
    step(4'b0000, 4'b0000, '0, 1'b1, "reset1");
    step(4'b0000, 4'b0000, '0, 1'b0, "idle");
    n_checks++;
    assert (bus.empty === 4'b1111 && bus.data_out === '0) else begin
      n_fail++; $error("FAIL idle_const empty %b data_out %h want 1111/0", bus.empty, bus.data_out);
    end

    // single push / pop on FIFO 0
    step(4'b0001, 4'b0000, 12'h096, 1'b0, "f0_push");
    step(4'b0000, 4'b0001, '0,      1'b0, "f0_pop");
    n_checks++;
    assert (bus.data_out[11:0] === 12'h096) else begin
      n_fail++; $error("FAIL f0_word got %h want 096", bus.data_out[11:0]);
    end

    // fill FIFO 2 past full, then drain
    for (int k = 0; k < 9; k++) step(4'b0100, 4'b0000, W'($urandom), 1'b0, "f2_fill");
    n_checks++;
    assert (bus.error[2] === 1'b1 && bus.full[2] === 1'b1) else begin
      n_fail++; $error("FAIL f2_overflow error %b full %b want 1/1", bus.error[2], bus.full[2]);
    end
    step(4'b0000, 4'b0000, '0, 1'b0, "f2_errpulse");
    for (int k = 0; k < 8; k++) step(4'b0000, 4'b0100, '0, 1'b0, "f2_drain");

    // push with pop on a full FIFO 1
    for (int k = 0; k < 8; k++) step(4'b0010, 4'b0000, 12'h8F0 + W'(k), 1'b0, "f1_fill");
    step(4'b0010, 4'b0010, 12'hDA0, 1'b0, "f1_full_pp");
    n_checks++;
    assert (bus.data_out[23:12] === 12'h8F0 && bus.full[1] === 1'b1) else begin
      n_fail++; $error("FAIL f1_full_pp word %h full %b want 8F0/1", bus.data_out[23:12], bus.full[1]);
    end
    for (int k = 0; k < 8; k++) step(4'b0000, 4'b0010, '0, 1'b0, "f1_drain");

    // push with pop on empty FIFO 3: no fall-through
    step(4'b1000, 4'b1000, 12'hE29, 1'b0, "f3_empty_pp");
    step(4'b0000, 4'b1000, '0,      1'b0, "f3_pop");
    n_checks++;
    assert (bus.data_out[47:36] === 12'hE29) else begin
      n_fail++; $error("FAIL f3_word got %h want E29", bus.data_out[47:36]);
    end

    // multi-bit push writes only the lowest index
    step(4'b0110, 4'b0000, 12'h5A5, 1'b0, "multi_push");
    step(4'b0000, 4'b0110, '0,      1'b0, "multi_pop");

    // interleaved traffic on FIFO 0 across wrap, reset mid-stream
    for (int k = 0; k < 20; k++) begin
      p = ($urandom_range(0, 2) != 0) ? 4'b0001 : 4'b0000;
      o = ($urandom_range(0, 2) == 0) ? 4'b0001 : 4'b0000;
      step(p, o, W'($urandom), (k == 13), "f0_wrap");
    end

    // random traffic on all FIFOs
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) p = 4'($urandom);
      else if ($urandom_range(0, 3) == 0) p = 4'b0000;
      else p = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < N_FIFO; i++) o[i] = ($urandom_range(0, 2) == 0);
      d = W'($urandom);
      step(p, o, d, ($urandom_range(0, 99) == 0), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_bank4.md
FIFO_BANK4 -- requirements
Module: fifo_bank4

Interface
REQ-001 The module SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Parameter DATA_W, default 12, word width.
REQ-003 Parameter DEPTH, default 8, entries per FIFO (power of two).
REQ-004 Parameter AF_THRESH, default 6, occupancy at or above which almost_full asserts.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  DATA_W  write word, shared by all four FIFOs.
REQ-008 push  input  4  per-FIFO write strobe, at most one bit set (arbiter output).
REQ-009 pop  input  4  per-FIFO read strobe, any combination.
REQ-010 data_out  output  4*DATA_W  registered read words; FIFO i in bits [i*DATA_W +: DATA_W].
REQ-011 empty  output  4  FIFO i holds zero entries.
REQ-012 almost_full  output  4  FIFO i occupancy >= AF_THRESH (back-pressure to arbiter).
REQ-013 full  output  4  FIFO i occupancy == DEPTH.
REQ-014 error  output  4  one-cycle pulse on overflow or underflow attempt for FIFO i.

Function
REQ-015 Each FIFO SHALL be an independent circular buffer with write pointer, read pointer and occupancy counter of $clog2(DEPTH)+1 bits.
REQ-016 push[i] with FIFO i not full at edge k SHALL write data_in at wr_ptr, increment wr_ptr mod DEPTH and increment the count.
REQ-017 pop[i] with FIFO i not empty at edge k SHALL load the head word into data_out slice i, visible from edge k until the next accepted pop; read latency is one cycle.
REQ-018 A rejected pop SHALL hold data_out slice i unchanged.
REQ-019 empty, full and almost_full SHALL be decoded combinationally from the registered count, so they change only at the edge where the count changes.
REQ-020 Simultaneous push and pop on a non-empty FIFO SHALL both be accepted, count unchanged, pointers both advanced.
REQ-021 Simultaneous push and pop on a full FIFO SHALL both be accepted, because the pop frees a slot in the same edge.
REQ-022 Simultaneous push and pop on an empty FIFO SHALL accept the push, reject the pop (no fall-through), and pulse error[i].
REQ-023 A push to a full FIFO without a pop SHALL be dropped, leaving memory, pointers and count unchanged, and pulse error[i] for one cycle.
REQ-024 A pop on an empty FIFO SHALL pulse error[i] for one cycle, leaving state unchanged.
REQ-025 If more than one push bit is set, the module SHALL write only to the lowest-index FIFO and pulse error on the others.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated word.

Reset
REQ-027 While reset is high at a clock edge, pointers and counts SHALL clear, giving empty=4'b1111, full=0, almost_full=0, error=0 and data_out=0.
REQ-028 Reset SHALL dominate push and pop in the same cycle, including mid-burst.
REQ-029 Memory contents SHALL NOT require reset.

Structure
REQ-030 A shared package SHALL hold DATA_W, N_FIFO=4, DEPTH and AF_THRESH, reused by the arbiter and its benches.
REQ-031 One sub-module, fifo_single (one FIFO with its flags and error), SHALL be instantiated four times.
REQ-032 The one-push-bit check (REQ-025) SHALL live in fifo_bank4.

Verification
REQ-033 Reset for 2 cycles, then idle: empty=4'b1111, almost_full=0, full=0, data_out=0, error=0.
REQ-034 Push 12'h096 into FIFO 0, then pop[0] the next cycle: empty[0] drops after the push edge; data_out[11:0]=12'h096 after the pop edge; empty[0]=1 again.
REQ-035 Six consecutive pushes to FIFO 2: almost_full[2] rises at the 6th edge; after 8 pushes full[2]=1; a 9th push gives error[2]=1 for one cycle and the count stays 8.
REQ-036 Fill FIFO 1 with 12'h8F0..12'h8F7, then push 12'hDA0 with pop[1] while full: the pop returns 12'h8F0, the push is accepted, full[1] stays 1, and there is no error.
REQ-037 On empty FIFO 3, push 12'hE29 with pop[3]: error[3]=1, data_out slice 3 unchanged, empty[3]=0; the next pop returns 12'hE29.
REQ-038 Run 20 interleaved push/pop operations on FIFO 0 across pointer wrap, asserting reset mid-stream: output order matches input order before reset, and all flags reach reset values at the reset edge.
